// File: rtl/addsub_pipe.sv
// Pipelined adder/subtractor: the WIDTH-bit carry chain is split into STAGES
// slices, one register stage per slice, with elastic valid/ready flow control.
module addsub_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SLICE = WIDTH / STAGES;

  logic [WIDTH-1:0]  b_eff;
  logic              c0;

  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] amsb_q, amsb_d;
  logic [STAGES-1:0] bmsb_q, bmsb_d;
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  always_comb begin
    b_eff = op[0] ? ~b : b;
    c0    = op[1] ? carry_in : op[0];
  end

  // Stage k advances unless it and every stage after it are full while the
  // consumer stalls; written flat to avoid a combinational self-reference.
  always_comb begin
    adv = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      adv[k] = out_ready;
      for (int unsigned j = k; j < STAGES; j++) begin
        if (!valid_q[j]) adv[k] = 1'b1;
      end
    end
  end

  always_comb begin
    logic             s_valid;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
    logic [WIDTH-1:0] s_res;
    logic             s_c;
    logic             s_amsb;
    logic             s_bmsb;
    logic [SLICE:0]   s_sum;
    int unsigned      p;

    valid_d = valid_q;
    carry_d = carry_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    res_d   = res_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    s_res   = '0;
    s_c     = 1'b0;
    s_amsb  = 1'b0;
    s_bmsb  = 1'b0;
    s_sum   = '0;
    p       = 0;

    for (int unsigned k = 0; k < STAGES; k++) begin
      p = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        s_valid = in_valid;
        s_a     = a;
        s_b     = b_eff;
        s_res   = '0;
        s_c     = c0;
        s_amsb  = a[WIDTH-1];
        s_bmsb  = b_eff[WIDTH-1];
      end else begin
        s_valid = valid_q[p];
        s_a     = opa_q[p];
        s_b     = opb_q[p];
        s_res   = res_q[p];
        s_c     = carry_q[p];
        s_amsb  = amsb_q[p];
        s_bmsb  = bmsb_q[p];
      end

      s_sum = {1'b0, s_a[k*SLICE +: SLICE]} + {1'b0, s_b[k*SLICE +: SLICE]}
            + {{SLICE{1'b0}}, s_c};

      if (adv[k]) begin
        valid_d[k] = s_valid;
        if (s_valid) begin
          res_d[k]                 = s_res;
          res_d[k][k*SLICE +: SLICE] = s_sum[SLICE-1:0];
          opa_d[k]                 = s_a;
          opb_d[k]                 = s_b;
          carry_d[k]               = s_sum[SLICE];
          amsb_d[k]                = s_amsb;
          bmsb_d[k]                = s_bmsb;
          // Flags are registered with the final slice so outputs are pure flops.
          if (k == STAGES - 1) begin
            cout_d = s_sum[SLICE];
            ovf_d  = (s_amsb == s_bmsb) && (res_d[k][WIDTH-1] != s_amsb);
            zero_d = (res_d[k] == '0);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      amsb_q  <= '0;
      bmsb_q  <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        res_q[k] <= res_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[STAGES-1];
  assign sum       = res_q[STAGES-1];
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/addsub_pipe.md
# addsub_pipe

Parametrised, pipelined integer adder/subtractor for the execute datapath. It replaces the single-cycle combinational N-bit adder wherever a wide carry chain limits clock frequency. The WIDTH-bit carry chain is split into STAGES equal slices, with one register stage per slice. The block adds subtract and carry/borrow-in modes, produces carry, overflow and zero flags, and uses valid/ready handshakes with full backpressure at one result per cycle.

## Interface
- WIDTH, default 32: operand/result width; must be a multiple of STAGES and at least 2.
- STAGES, default 2: number of pipeline stages (1..4). SLICE = WIDTH/STAGES bits are resolved per stage.
- clk  input  1: single clock; all state updates on the rising edge.
- rst_n  input  1: reset, synchronous and active-low.
- in_valid  input  1: operand bundle valid.
- in_ready  output  1: block can accept a bundle this cycle.
- op  input  2: operation select.
  - 00: a+b
  - 01: a-b
  - 10: a+b+carry_in
  - 11: a+~b+carry_in (subtract with borrow)
- carry_in  input  1: used only for op 10/11.
- a  input  WIDTH: operand A.
- b  input  WIDTH: operand B.
- out_valid  output  1: result bundle valid.
- out_ready  input  1: consumer accepts result.
- sum  output  WIDTH: result, modulo 2^WIDTH.
- carry_out  output  1: carry out of bit WIDTH-1 of the internal sum a + b' + c0.
- overflow  output  1: signed two's-complement overflow.
- zero  output  1: sum == 0.

## Operation
- Effective operands:
  - b' = b for op 00/10; b' = ~b for op 01/11.
  - c0 = 0 for op 00; c0 = 1 for op 01; c0 = carry_in for op 10/11.
- Stage k (0..STAGES-1) computes bits [k*SLICE +: SLICE] of a + b' + carry, where carry is c0 for k=0 and the registered carry from stage k-1 otherwise.
- Each stage register holds:
  - the completed low result bits;
  - the unconsumed upper slices of a and b';
  - the pending carry;
  - a_msb and b'_msb;
  - a valid bit.
- Output flags, computed from the final stage:
  - carry_out = carry out of the top slice.
  - overflow = (a_msb == b'_msb) && (sum[WIDTH-1] != a_msb).
  - zero = (sum == 0).
- Subtraction carry convention: carry_out = 1 means no borrow (a >= b unsigned for op 01).
- Elastic pipeline. Stage k advances when it is empty or stage k+1 advances; the last stage advances when !out_valid || out_ready.
- in_ready = stage 0 advances. in_ready is a combinational function of the stage valid bits and out_ready only; it does not depend on in_valid.
- A bundle is accepted on a cycle with in_valid && in_ready. A result is consumed on a cycle with out_valid && out_ready.
- While out_valid && !out_ready, sum and all flags hold stable, and the bundle behind them holds in place.
- Bundles are never dropped, duplicated or reordered.

## Timing
- Latency: a bundle accepted at edge t appears with out_valid=1 after edge t+STAGES-1. With STAGES=1 it is registered at the same edge, so it is visible the next cycle.
- Throughput: one bundle per cycle while out_ready=1. There are no bubbles when the pipeline is full and drains simultaneously.
- Reset (rst_n=0 at an edge):
  - all valid bits clear;
  - out_valid=0, sum=0, carry_out=0, overflow=0, zero=0;
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight bundles; no partial result is ever presented.
- Reset has priority over acceptance: a bundle offered at a reset edge is not accepted.
- Simultaneous accept and consume on a full pipeline: all stages shift and occupancy is unchanged.
- Wrap-around: the result is modulo 2^WIDTH, and the carry is reported only via carry_out.
- No combinational path from a/b/op to any output; all outputs come directly from the final stage registers.

## Test plan
- Reset and latency (WIDTH=32, STAGES=2):
  - Hold rst_n=0 for 3 cycles -> out_valid=0, all outputs 0, in_ready=1.
  - Then a=0x0000_0005, b=0x0000_0003, op=00 -> sum=0x0000_0008, carry_out=0, overflow=0, zero=0, valid exactly 2 edges after acceptance.
- Cross-slice carry and wrap-around (WIDTH=32, STAGES=2):
  - a=0xFFFF_FFFF, b=0x0000_0001, op=00 -> sum=0x0000_0000, carry_out=1, zero=1, overflow=0.
  - a=0x0000_FFFF, b=1 -> sum=0x0001_0000 (carry crosses the slice boundary).
- Subtract and signed overflow (WIDTH=32, STAGES=2):
  - a=0x8000_0000, b=1, op=01 -> sum=0x7FFF_FFFF, overflow=1, carry_out=1.
  - a=3, b=5, op=01 -> sum=0xFFFF_FFFE, carry_out=0.
  - a=0x7FFF_FFFF, b=1, op=00 -> overflow=1.
- Carry-in modes (WIDTH=32, STAGES=2):
  - op=10, a=1, b=1, carry_in=1 -> sum=3.
  - op=11, a=5, b=2, carry_in=0 -> sum=2 (5-2-1).
  - op=11, a=5, b=2, carry_in=1 -> sum=3.
- Backpressure (WIDTH=32, STAGES=2):
  - Stream 8 bundles with in_valid=1 continuously while toggling out_ready 1,0,0,1,...
  - Required: every result is stable while stalled; all 8 results emerge in order, none lost or duplicated; in_ready=0 only while the pipeline is full and out_ready=0.
  - With out_ready held at 1, one result per cycle.
- Reset mid-flight and parameter sweep:
  - Assert rst_n=0 with 2 bundles in flight -> neither bundle ever appears; out_valid=0 the cycle after.
  - Repeat the random-vs-model comparison for WIDTH/STAGES = 8/1, 16/4, 64/4, 32/2 (1000 random bundles each, including op 00..11). All sum/flag values must match the reference arithmetic.
